// File: rtl/set_assoc_cache.sv
// Purpose : 2-way set-associative cache with per-set LRU, write-through/no-write-allocate stores,
//           and an integrated block-fill FSM. Serves as either the I-cache or the D-cache.
// Latency : hits return data combinationally in the request cycle; a read miss stalls for
//           WORDS memory beats + 2 cycles (1 lookup cycle + fill beats + 1 update cycle).
// Backpressure: stall holds the pipeline through FILL/UPDATE; each fill word address is held until
//           MemDataValid; write-through stores are accepted by memory in the same cycle, never stall.
//
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   pipe_MemRead/pipe_MemWrite - pipeline request strobes (write wins when both are set)
//   pipe_addr/pipe_write_data  - request byte address and store data
//   MemDataValid/mem_read_data - fill beat from memory
//   cache_MemRead              - fill read request (asserted throughout FILL)
//   cache_MemWrite             - write-through store strobe
//   cache_mem_addr             - fill word address, or store address during a store
//   cache_mem_write_data       - store data
//   cache_data_out/cachehit    - hit data / hit flag for the current request
//   stall                      - pipeline must hold its request
module set_assoc_cache #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int SETS   = 64,
  parameter int WORDS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_MemRead,
  input  logic              pipe_MemWrite,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_write_data,
  input  logic              MemDataValid,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              cache_MemRead,
  output logic              cache_MemWrite,
  output logic [ADDR_W-1:0] cache_mem_addr,
  output logic [DATA_W-1:0] cache_mem_write_data,
  output logic [DATA_W-1:0] cache_data_out,
  output logic              stall,
  output logic              cachehit
);

  // Geometry. CNT_W is the word-within-block index width; OFF_W adds the byte bit.
  localparam int CNT_W = $clog2(WORDS);
  localparam int OFF_W = CNT_W + 1;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;

  // ---------------------------------------------------------------------------
  // Request address split
  // ---------------------------------------------------------------------------
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [CNT_W-1:0] req_word;
  logic             unused_addr_lsb;

  assign req_tag         = pipe_addr[ADDR_W-1 -: TAG_W];
  assign req_idx         = pipe_addr[OFF_W +: IDX_W];
  assign req_word        = pipe_addr[1 +: CNT_W];
  // Byte-select bit: the cache is word-granular.
  assign unused_addr_lsb = pipe_addr[0];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] fill_tag;
  logic [IDX_W-1:0] fill_idx;
  logic             victim;

  // Control bits are reset; tags and data are not (they are qualified by valid).
  logic [SETS-1:0]   valid0;
  logic [SETS-1:0]   valid1;
  logic [SETS-1:0]   lru;      // names the way to evict next
  logic [TAG_W-1:0]  tag0  [SETS];
  logic [TAG_W-1:0]  tag1  [SETS];
  logic [DATA_W-1:0] data0 [SETS][WORDS];
  logic [DATA_W-1:0] data1 [SETS][WORDS];

  // ---------------------------------------------------------------------------
  // Combinational lookup
  // ---------------------------------------------------------------------------
  logic              idle;
  logic              any_req;
  logic              rd_req;
  logic              hit0;
  logic              hit1;
  logic              hit;
  logic              hit_way;
  logic              rd_miss;
  logic              new_victim;
  logic [DATA_W-1:0] hit_word;

  assign idle    = (state == ST_IDLE);
  assign any_req = pipe_MemRead | pipe_MemWrite;
  // A store takes priority, so a read only counts when no write is present.
  assign rd_req  = pipe_MemRead & ~pipe_MemWrite;

  assign hit0 = valid0[req_idx] & (tag0[req_idx] == req_tag);
  assign hit1 = valid1[req_idx] & (tag1[req_idx] == req_tag);

  // Lookup results only mean something in IDLE; FILL/UPDATE ignore the pipeline.
  assign hit     = idle & any_req & (hit0 | hit1);
  // Both ways never hold the same tag, so way1-hit alone selects the way.
  assign hit_way = hit1;
  assign rd_miss = idle & rd_req & ~(hit0 | hit1);

  assign hit_word = hit_way ? data1[req_idx][req_word] : data0[req_idx][req_word];

  assign cachehit       = hit;
  assign cache_data_out = hit ? hit_word : '0;

  // Any non-IDLE state holds the pipeline, including an unreachable encoding.
  assign stall          = rd_miss | ~idle;
  assign cache_MemRead  = (state == ST_FILL);
  assign cache_MemWrite = idle & pipe_MemWrite;

  // Prefer an empty way; otherwise evict the LRU way.
  always_comb begin
    new_victim = lru[req_idx];
    if (!valid0[req_idx]) begin
      new_victim = 1'b0;
    end else if (!valid1[req_idx]) begin
      new_victim = 1'b1;
    end
  end

  // Memory-side address/data: fill address while filling, store address during a
  // write-through, zero otherwise so idle outputs are quiet.
  always_comb begin
    cache_mem_addr       = '0;
    cache_mem_write_data = '0;
    if (state == ST_FILL) begin
      cache_mem_addr = {fill_tag, fill_idx, cnt, 1'b0};
    end else if (cache_MemWrite) begin
      cache_mem_addr       = pipe_addr;
      cache_mem_write_data = pipe_write_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM, valid and LRU bits
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      fill_tag <= '0;
      fill_idx <= '0;
      victim   <= 1'b0;
      valid0   <= '0;
      valid1   <= '0;
      lru      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hit) begin
            // Read or write hit: the other way becomes the next victim.
            lru[req_idx] <= ~hit_way;
          end else if (rd_miss) begin
            fill_tag <= req_tag;
            fill_idx <= req_idx;
            victim   <= new_victim;
            cnt      <= '0;
            // Invalidate up front so a half-filled block can never hit.
            if (new_victim) begin
              valid1[req_idx] <= 1'b0;
            end else begin
              valid0[req_idx] <= 1'b0;
            end
            state <= ST_FILL;
          end
          // Write misses go straight through to memory: no state change.
        end

        ST_FILL: begin
          if (MemDataValid) begin
            // Wraps to zero exactly on the last beat, as the FSM leaves FILL.
            cnt <= cnt + CNT_ONE;
            if (cnt == CNT_LAST) begin
              state <= ST_UPDATE;
            end
          end
        end

        ST_UPDATE: begin
          if (victim) begin
            valid1[fill_idx] <= 1'b1;
          end else begin
            valid0[fill_idx] <= 1'b1;
          end
          lru[fill_idx] <= ~victim;
          state         <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Tag and data arrays (no reset; contents only matter when valid)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      // Write-hit update; the store also goes to memory this cycle.
      if (hit && pipe_MemWrite) begin
        if (hit_way) begin
          data1[req_idx][req_word] <= pipe_write_data;
        end else begin
          data0[req_idx][req_word] <= pipe_write_data;
        end
      end

      if ((state == ST_FILL) && MemDataValid) begin
        if (victim) begin
          data1[fill_idx][cnt] <= mem_read_data;
        end else begin
          data0[fill_idx][cnt] <= mem_read_data;
        end
      end

      if (state == ST_UPDATE) begin
        if (victim) begin
          tag1[fill_idx] <= fill_tag;
        end else begin
          tag0[fill_idx] <= fill_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
module tb_set_assoc_cache;

  logic        clk;
  logic        rst;
  logic        pipe_MemRead;
  logic        pipe_MemWrite;
  logic [15:0] pipe_addr;
  logic [15:0] pipe_write_data;
  logic        MemDataValid;
  logic [15:0] mem_read_data;
  logic        cache_MemRead;
  logic        cache_MemWrite;
  logic [15:0] cache_mem_addr;
  logic [15:0] cache_mem_write_data;
  logic [15:0] cache_data_out;
  logic        stall;
  logic        cachehit;

  int pass_cnt  = 0;
  int total_cnt = 0;

  set_assoc_cache #(
    .ADDR_W(16),
    .DATA_W(16),
    .SETS  (64),
    .WORDS (8)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .pipe_MemRead        (pipe_MemRead),
    .pipe_MemWrite       (pipe_MemWrite),
    .pipe_addr           (pipe_addr),
    .pipe_write_data     (pipe_write_data),
    .MemDataValid        (MemDataValid),
    .mem_read_data       (mem_read_data),
    .cache_MemRead       (cache_MemRead),
    .cache_MemWrite      (cache_MemWrite),
    .cache_mem_addr      (cache_mem_addr),
    .cache_mem_write_data(cache_mem_write_data),
    .cache_data_out      (cache_data_out),
    .stall               (stall),
    .cachehit            (cachehit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents model: every word address holds a distinct value.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[15:1], 1'b0} ^ 16'hA5A5;
  endfunction

  // Advance to just after the next rising edge; inputs are driven here,
  // outputs are sampled on the following falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full read-miss sequence: lookup cycle, 8 fill beats each preceded by `gap`
  // idle memory cycles, the update cycle, then the re-lookup hit.
  task automatic read_miss(input logic [15:0] a, input int gap,
                           output int stall_cycles, output logic [15:0] hit_data);
    logic [15:0] base;
    logic [15:0] exp_addr;
    base         = {a[15:4], 4'h0};
    stall_cycles = 0;
    tick();
    pipe_MemRead  = 1'b1;
    pipe_MemWrite = 1'b0;
    pipe_addr     = a;
    @(negedge clk);
    if (stall === 1'b1) stall_cycles++;
    total_cnt++;
    if (stall !== 1'b1 || cachehit !== 1'b0)
      $display("FAIL miss_lookup %h: stall=%b cachehit=%b, required stall=1 cachehit=0", a, stall, cachehit);
    else pass_cnt++;
    for (int b = 0; b < 8; b++) begin
      exp_addr = base + 16'(2 * b);
      for (int g = 0; g <= gap; g++) begin
        tick();
        MemDataValid  = (g == gap);
        mem_read_data = (g == gap) ? mem_word(exp_addr) : 16'h0000;
        @(negedge clk);
        if (stall === 1'b1) stall_cycles++;
        total_cnt++;
        if (cache_MemRead !== 1'b1 || cache_mem_addr !== exp_addr || stall !== 1'b1)
          $display("FAIL fill_beat%0d_cyc%0d: MemRead=%b addr=%h stall=%b, required 1 %h 1",
                   b, g, cache_MemRead, cache_mem_addr, stall, exp_addr);
        else pass_cnt++;
      end
    end
    tick();
    MemDataValid  = 1'b0;
    mem_read_data = 16'h0000;
    @(negedge clk);
    if (stall === 1'b1) stall_cycles++;
    total_cnt++;
    if (stall !== 1'b1 || cache_MemRead !== 1'b0)
      $display("FAIL update_cycle %h: stall=%b MemRead=%b, required stall=1 MemRead=0", a, stall, cache_MemRead);
    else pass_cnt++;
    tick();
    @(negedge clk);
    hit_data = cache_data_out;
    total_cnt++;
    if (stall !== 1'b0 || cachehit !== 1'b1 || cache_data_out !== mem_word(a))
      $display("FAIL refill_hit %h: stall=%b hit=%b data=%h, required 0 1 %h",
               a, stall, cachehit, cache_data_out, mem_word(a));
    else pass_cnt++;
    tick();
    pipe_MemRead = 1'b0;
  endtask

  // Single-cycle read that must hit with the given data.
  task automatic read_hit(input logic [15:0] a, input logic [15:0] exp_data);
    tick();
    pipe_MemRead  = 1'b1;
    pipe_MemWrite = 1'b0;
    pipe_addr     = a;
    @(negedge clk);
    total_cnt++;
    if (cachehit !== 1'b1 || stall !== 1'b0 || cache_data_out !== exp_data)
      $display("FAIL read_hit %h: hit=%b stall=%b data=%h, required 1 0 %h",
               a, cachehit, stall, cache_data_out, exp_data);
    else pass_cnt++;
    tick();
    pipe_MemRead = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({cache_MemRead, cache_MemWrite, stall, cachehit} !== 4'b0000 ||
        cache_mem_addr !== 16'h0 || cache_mem_write_data !== 16'h0 || cache_data_out !== 16'h0)
      $display("FAIL reset_outputs: rd=%b wr=%b stall=%b hit=%b addr=%h wdat=%h dout=%h, required all zero",
               cache_MemRead, cache_MemWrite, stall, cachehit, cache_mem_addr,
               cache_mem_write_data, cache_data_out);
    else pass_cnt++;
  endtask

  task automatic test_cold_miss();
    int          sc;
    logic [15:0] d;
    read_miss(16'h0124, 0, sc, d);
    total_cnt++;
    if (d !== 16'hA481) $display("FAIL cold_miss_data: got %h, required %h", d, 16'hA481);
    else pass_cnt++;
    total_cnt++;
    if (sc !== 10) $display("FAIL cold_miss_stall_cycles: got %0d, required %0d", sc, 10);
    else pass_cnt++;
  endtask

  task automatic test_fill_gap();
    int          sc;
    logic [15:0] d;
    read_miss(16'h0546, 3, sc, d);
    total_cnt++;
    if (sc !== 34) $display("FAIL gap_stall_cycles: got %0d, required %0d", sc, 34);
    else pass_cnt++;
  endtask

  task automatic test_conflict_lru();
    int          sc;
    logic [15:0] d;
    read_miss(16'h0100, 0, sc, d);          // set 16 -> way0
    read_miss(16'h1100, 0, sc, d);          // set 16 -> way1
    read_hit(16'h0100, mem_word(16'h0100)); // way1 becomes LRU
    read_hit(16'h1100, mem_word(16'h1100)); // way0 becomes LRU
    read_hit(16'h0100, mem_word(16'h0100)); // way1 LRU again
    read_miss(16'h2100, 0, sc, d);          // must evict 0x1100
    read_hit(16'h0100, mem_word(16'h0100));
    read_miss(16'h1100, 0, sc, d);          // lookup must miss
  endtask

  task automatic test_write_hit();
    tick();
    pipe_MemWrite   = 1'b1;
    pipe_addr       = 16'h0102;
    pipe_write_data = 16'hBEEF;
    @(negedge clk);
    total_cnt++;
    if (cache_MemWrite !== 1'b1 || cache_mem_addr !== 16'h0102 || cache_mem_write_data !== 16'hBEEF ||
        stall !== 1'b0 || cachehit !== 1'b1 || cache_MemRead !== 1'b0)
      $display("FAIL write_hit: wr=%b addr=%h wdat=%h stall=%b hit=%b rd=%b, required 1 0102 beef 0 1 0",
               cache_MemWrite, cache_mem_addr, cache_mem_write_data, stall, cachehit, cache_MemRead);
    else pass_cnt++;
    tick();
    pipe_MemWrite = 1'b0;
    read_hit(16'h0102, 16'hBEEF);
    read_hit(16'h0104, mem_word(16'h0104));
  endtask

  task automatic test_write_miss();
    int          sc;
    logic [15:0] d;
    tick();
    pipe_MemWrite   = 1'b1;
    pipe_addr       = 16'h3000;
    pipe_write_data = 16'h1234;
    @(negedge clk);
    total_cnt++;
    if (cache_MemWrite !== 1'b1 || cache_mem_addr !== 16'h3000 || cache_mem_write_data !== 16'h1234 ||
        stall !== 1'b0 || cachehit !== 1'b0)
      $display("FAIL write_miss: wr=%b addr=%h wdat=%h stall=%b hit=%b, required 1 3000 1234 0 0",
               cache_MemWrite, cache_mem_addr, cache_mem_write_data, stall, cachehit);
    else pass_cnt++;
    tick();
    pipe_MemWrite = 1'b0;
    read_miss(16'h3000, 0, sc, d);
  endtask

  task automatic test_reset_mid_fill();
    int          sc;
    logic [15:0] d;
    tick();
    pipe_MemRead = 1'b1;
    pipe_addr    = 16'h4240;
    for (int b = 0; b < 5; b++) begin
      tick();
      MemDataValid  = 1'b1;
      mem_read_data = mem_word(16'h4240 + 16'(2 * b));
    end
    tick();
    MemDataValid  = 1'b0;
    pipe_MemRead  = 1'b0;
    rst           = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (cache_MemRead !== 1'b0 || stall !== 1'b0 || cache_mem_addr !== 16'h0)
      $display("FAIL post_reset_idle: rd=%b stall=%b addr=%h, required 0 0 0000",
               cache_MemRead, stall, cache_mem_addr);
    else pass_cnt++;
    read_miss(16'h4240, 0, sc, d);          // restarts at word 0
    tick();
    pipe_MemWrite   = 1'b1;
    pipe_addr       = 16'h0102;
    pipe_write_data = 16'h5555;
    @(negedge clk);
    total_cnt++;
    if (cachehit !== 1'b0 || stall !== 1'b0 || cache_MemWrite !== 1'b1)
      $display("FAIL post_reset_write: hit=%b stall=%b wr=%b, required 0 0 1", cachehit, stall, cache_MemWrite);
    else pass_cnt++;
    tick();
    pipe_MemWrite = 1'b0;
    read_miss(16'h0100, 0, sc, d);
    read_miss(16'h0124, 0, sc, d);
  endtask

  initial begin
    rst             = 1'b1;
    pipe_MemRead    = 1'b0;
    pipe_MemWrite   = 1'b0;
    pipe_addr       = 16'h0000;
    pipe_write_data = 16'h0000;
    MemDataValid    = 1'b0;
    mem_read_data   = 16'h0000;
    test_reset();
    test_cold_miss();
    test_fill_gap();
    test_conflict_lru();
    test_write_hit();
    test_write_miss();
    test_reset_mid_fill();
    repeat (2) tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
